dna_hex_tx: RTL

DNA_HEX_TX -- requirements
Module: dna_hex_tx

---
 rtl/dna_hex_if.sv | 18 +
 rtl/dna_hex_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dna_hex_if.sv
// Byte stream carrying the ASCII DNA report: valid/ready handshake, one byte per transfer.
interface dna_hex_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/dna_hex_tx.sv
// Transmits a captured 57-bit device DNA as 15 uppercase hex ASCII digits over a byte stream.
// Optional CR/LF terminator enabled by defining DNA_HEX_CRLF_EN.
module dna_hex_tx #(
    parameter bit AUTO_SEND = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [56:0]       id,
    input  logic              id_valid,
    input  logic              req,
    dna_hex_if.master         tx,
    output logic              busy,
    output logic              done
);

`ifdef DNA_HEX_CRLF_EN
    localparam int unsigned LEN = 17;
`else
    localparam int unsigned LEN = 15;
`endif
    localparam logic [4:0] LAST_IDX = 5'(LEN - 1);

    typedef enum logic [1:0] {
        ST_WAIT_ID = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    state_t      state_r;
    logic [56:0] id_r;
    logic [56:0] snap_r;
    logic        id_valid_q_r;
    logic [4:0]  idx_r;
    logic [7:0]  tdata_r;
    logic        tvalid_r;
    logic        busy_r;
    logic        done_r;

    logic        id_edge_s;
    logic [56:0] start_src_s;
    logic        xfer_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    // Byte i of the report: digits of {3'b000, v} MSD first, then the optional terminator.
    function automatic logic [7:0] report_byte(input logic [56:0] v, input logic [4:0] i);
        logic [59:0] w;
        logic [7:0]  amt;
        logic [7:0]  b;
        w   = {3'b000, v};
        amt = 8'd0;
        case (i)
            5'd15:   b = 8'h0D;
            5'd16:   b = 8'h0A;
            default: begin
                if (i < 5'd15) begin
                    amt = 8'd4 * (8'd14 - {3'b000, i});
                    b   = hex_ascii(4'(w >> amt));
                end else begin
                    b = 8'h00;
                end
            end
        endcase
        return b;
    endfunction

    assign id_edge_s   = id_valid & ~id_valid_q_r;
    // A fresh edge in the same cycle as a start wins over the previously held id.
    assign start_src_s = id_edge_s ? id : id_r;
    assign xfer_s      = tvalid_r & tx.tready;

    assign tx.tdata  = tdata_r;
    assign tx.tvalid = tvalid_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Report sequencer: id capture, start decisions and byte streaming with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_WAIT_ID;
            id_r         <= 57'd0;
            snap_r       <= 57'd0;
            id_valid_q_r <= 1'b0;
            idx_r        <= 5'd0;
            tdata_r      <= 8'h00;
            tvalid_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            id_valid_q_r <= id_valid;
            done_r       <= 1'b0;
            if (id_edge_s) begin
                id_r <= id;
            end else begin
                id_r <= id_r;
            end

            case (state_r)
                ST_WAIT_ID: begin
                    if (id_edge_s && AUTO_SEND) begin
                        state_r  <= ST_SEND;
                        snap_r   <= start_src_s;
                        idx_r    <= 5'd0;
                        tdata_r  <= report_byte(start_src_s, 5'd0);
                        tvalid_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else if (id_edge_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_ID;
                    end
                end

                ST_IDLE: begin
                    if (req) begin
                        state_r  <= ST_SEND;
                        snap_r   <= start_src_s;
                        idx_r    <= 5'd0;
                        tdata_r  <= report_byte(start_src_s, 5'd0);
                        tvalid_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_SEND: begin
                    // snap_r freezes the report so a new id edge only affects the next one.
                    if (xfer_s && (idx_r == LAST_IDX)) begin
                        state_r  <= ST_IDLE;
                        idx_r    <= 5'd0;
                        tdata_r  <= 8'h00;
                        tvalid_r <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else if (xfer_s) begin
                        idx_r   <= idx_r + 5'd1;
                        tdata_r <= report_byte(snap_r, idx_r + 5'd1);
                    end else begin
                        idx_r   <= idx_r;
                        tdata_r <= tdata_r;
                    end
                end

                default: begin
                    state_r  <= ST_WAIT_ID;
                    idx_r    <= 5'd0;
                    tdata_r  <= 8'h00;
                    tvalid_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule
